// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage 16-bit core: stage enables,
// bubble/flush controls, HLT drain sequencing and a saturating stall counter.
module pipe_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_SrcReg1,
    input  logic [3:0]       id_SrcReg2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_hlt,
    input  logic             ex_Data_Mem_en,
    input  logic             ex_Data_Mem_wr,
    input  logic             ex_WriteReg,
    input  logic [3:0]       ex_DstReg,
    input  logic             ex_branch_taken,
    input  logic             imem_stall,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_DRAIN    = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] cnt_q;
    logic             stall_cycle;
    logic             load_use;

    // Only a load that really writes a non-zero register can feed ID too late.
    assign load_use = ex_Data_Mem_en && !ex_Data_Mem_wr && ex_WriteReg &&
                      (ex_DstReg != 4'd0) &&
                      ((id_use1 && (id_SrcReg1 == ex_DstReg)) ||
                       (id_use2 && (id_SrcReg2 == ex_DstReg)));

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_bubble = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        halted      = 1'b0;
        stall_cycle = 1'b0;
        state_d     = state_q;
        drain_d     = drain_q;

        case (state_q)
            S_RUN: begin
                if (dmem_busy) begin
                    stall_cycle = 1'b1;
                    state_d     = S_MEM_WAIT;
                end else if (ex_branch_taken) begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_en     = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                end else if (load_use) begin
                    idex_en     = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                    stall_cycle = 1'b1;
                end else if (imem_stall) begin
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_en     = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                    stall_cycle = 1'b1;
                end else if (id_hlt) begin
                    // HLT itself moves into EX; fetch is frozen from here on.
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_en     = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                    stall_cycle = 1'b1;
                    drain_d     = DW'(DRAIN_CYCLES);
                    state_d     = S_DRAIN;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                end
            end

            S_MEM_WAIT: begin
                if (dmem_busy) begin
                    stall_cycle = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                    state_d  = S_RUN;
                end
            end

            S_DRAIN: begin
                stall_cycle = 1'b1;
                if (!dmem_busy) begin
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_en     = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                    drain_d     = drain_q - DW'(1);
                    if (drain_q <= DW'(1)) begin
                        state_d = S_HALT;
                    end
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            drain_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (stall_cycle && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage 16-bit core. It drives the write enables and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It handles load-use stalls, taken-branch flushes, instruction- and data-memory wait states, and the HLT drain sequence. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
DRAIN_CYCLES, 3, cycles from HLT leaving ID until `halted` asserts (EX, MEM and WB drain)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
id_SrcReg1  in  4  ID-stage source register 1
id_SrcReg2  in  4  ID-stage source register 2
id_use1  in  1  ID instruction reads SrcReg1
id_use2  in  1  ID instruction reads SrcReg2
id_hlt  in  1  ID instruction is HLT
ex_Data_Mem_en  in  1  EX-stage instruction accesses data memory (ID/EX output)
ex_Data_Mem_wr  in  1  EX-stage access is a store
ex_WriteReg  in  1  EX-stage instruction writes the register file
ex_DstReg  in  4  EX-stage destination register
ex_branch_taken  in  1  branch resolved taken in EX this cycle
imem_stall  in  1  instruction fetch not ready this cycle
dmem_busy  in  1  data memory not ready (level; MEM stage must hold)
pc_en  out  1  PC write enable
ifid_en  out  1  IF/ID write enable
ifid_flush  out  1  IF/ID loads a NOP this cycle
idex_en  out  1  ID/EX write enable
idex_bubble  out  1  zero all ID/EX control fields (Data_Mem_en, Data_Mem_wr, WriteReg) on this load
exmem_en  out  1  EX/MEM write enable
memwb_en  out  1  MEM/WB write enable
halted  out  1  core halted
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- FSM states: RUN, MEM_WAIT, DRAIN, HALT. Reset (rst=0, asynchronous): state=RUN, drain counter=0, stall_cnt=0, halted=0.
- Outputs are combinational from the current state and inputs. The state, drain counter and stall_cnt are registered.
- Load-use hazard (LU): ex_Data_Mem_en & ~ex_Data_Mem_wr & ex_WriteReg & ex_DstReg!=0 & ((id_use1 & id_SrcReg1==ex_DstReg) | (id_use2 & id_SrcReg2==ex_DstReg)).
- RUN, evaluated in priority order:
  1. dmem_busy: every enable = 0, no bubble or flush, next state MEM_WAIT.
  2. ex_branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_bubble=1, exmem_en=memwb_en=1. Flush squashes any same-cycle LU, imem_stall or id_hlt.
  3. LU: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1, exmem_en=memwb_en=1. Stall lasts exactly one cycle.
  4. imem_stall: pc_en=0, ifid_en=1, ifid_flush=1. All later stages enabled.
  5. id_hlt: pc_en=0, ifid_en=1, ifid_flush=1, idex_en=1 (HLT advances), exmem_en=memwb_en=1. Load drain counter with DRAIN_CYCLES, next state DRAIN.
  6. Otherwise: all enables = 1, no bubble or flush.
- MEM_WAIT:
  - While dmem_busy=1: all enables = 0.
  - When dmem_busy=0: all enables = 1 and next state RUN.
  - Hazards in ID are not evaluated in this state. They are re-evaluated in RUN on the following cycle.
- DRAIN:
  - pc_en=0, ifid_flush=1, ifid_en=1, idex_en=1, idex_bubble=1.
  - dmem_busy=1 holds every enable at 0 and freezes the counter.
  - Otherwise exmem_en=memwb_en=1 and the counter decrements. At 1→0 the next state is HALT.
  - ex_branch_taken is ignored in DRAIN: only HLT and older instructions are live.
- HALT: every enable = 0 and halted=1. The state persists until reset.
- stall_cnt increments on each cycle in RUN, MEM_WAIT or DRAIN where pc_en=0 or dmem_busy holds the pipe. It saturates at all-ones and never wraps. It does not count in HALT.
- Reset mid-MEM_WAIT or mid-DRAIN returns to RUN immediately and asynchronously. Outputs then reflect RUN with the current inputs.

Test Plan:
- LU: LW R3 in EX (ex_Data_Mem_en=1, wr=0, WriteReg=1, DstReg=3), ID reads R3 via use1 → one cycle of pc_en=0, ifid_en=0, idex_bubble=1. The next cycle has all enables 1. stall_cnt=1.
- R0 / store filter: same as above with DstReg=0, or with ex_Data_Mem_wr=1 → no stall, all enables 1.
- Branch vs LU: ex_branch_taken=1 and LU true in the same cycle → ifid_flush=1, idex_bubble=1, pc_en=1. No stall; stall_cnt unchanged.
- MEM_WAIT: dmem_busy high for 4 cycles → all enables 0 for 4 cycles, then all enables 1 and state RUN. stall_cnt=4.
- HLT drain: id_hlt=1 in RUN → 3 DRAIN cycles with pc_en=0, then halted=1 and all enables 0 thereafter. Same test with dmem_busy=1 for 2 cycles inside DRAIN → halted arrives 2 cycles later.
- Async reset and saturation:
  - Pulse rst low mid-DRAIN between clock edges → state RUN and stall_cnt=0 before the next edge.
  - With CNT_W=4, force 20 stalled cycles → stall_cnt=15.
